// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared bfloat16 constants and sequencer state encoding
package mac_pkg;

    localparam int BF16_WIDTH     = 16;
    localparam int BF16_EXP_WIDTH = 8;
    localparam int BF16_MAN_WIDTH = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    localparam logic [BF16_WIDTH-1:0] ONE       = 16'h3F80;
    localparam logic [BF16_WIDTH-1:0] ZERO      = 16'h0000;
    localparam logic [BF16_WIDTH-1:0] BF16_QNAN = 16'h7FC0;

endpackage

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - combinational bfloat16 a*b+c, exact sum truncated toward zero
// Subnormal inputs read as zero; tiny results flush to signed zero.
module mac_unit
    import mac_pkg::*;
(
    input  logic [BF16_WIDTH-1:0] in_a,
    input  logic [BF16_WIDTH-1:0] in_b,
    input  logic [BF16_WIDTH-1:0] in_c,
    output logic [BF16_WIDTH-1:0] mac_out,
    output logic                  exception,
    output logic                  overflow,
    output logic                  underflow
);

    logic [BF16_EXP_WIDTH-1:0] ea, eb, ec;
    logic                      sp, sc, eff_sub, res_sign;
    logic                      a_nan, b_nan, c_nan, a_inf, b_inf, c_inf;
    logic                      a_zero, b_zero, c_zero, p_zero, p_inf;
    logic [15:0]               prod;
    logic signed [11:0]        top_p, top_c, top, sh_p_s, sh_c_s, e_res;
    logic [6:0]                sh_p, sh_c;
    logic [95:0]               wide_p, wide_c;
    logic [48:0]               al_p, al_c, sum;
    logic [5:0]                msb;
    logic [BF16_MAN_WIDTH-1:0] man;

    assign ea     = in_a[14:7];
    assign eb     = in_b[14:7];
    assign ec     = in_c[14:7];
    assign sp     = in_a[15] ^ in_b[15];
    assign sc     = in_c[15];
    assign a_nan  = (ea == 8'hFF) && (in_a[6:0] != 7'd0);
    assign b_nan  = (eb == 8'hFF) && (in_b[6:0] != 7'd0);
    assign c_nan  = (ec == 8'hFF) && (in_c[6:0] != 7'd0);
    assign a_inf  = (ea == 8'hFF) && (in_a[6:0] == 7'd0);
    assign b_inf  = (eb == 8'hFF) && (in_b[6:0] == 7'd0);
    assign c_inf  = (ec == 8'hFF) && (in_c[6:0] == 7'd0);
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
    assign c_zero = (ec == 8'd0);
    assign p_zero = a_zero | b_zero;
    assign p_inf  = a_inf | b_inf;
    assign prod   = 16'({1'b1, in_a[6:0]}) * 16'({1'b1, in_b[6:0]});

    // Exponent of the top bit of each left-justified significand
    assign top_p  = $signed({4'b0, ea}) + $signed({4'b0, eb}) - 12'sd253;
    assign top_c  = $signed({4'b0, ec}) - 12'sd127;
    assign eff_sub = sp ^ sc;

    always_comb begin
        top = top_p;
        if (p_zero)
            top = top_c;
        else if (!c_zero && (top_c > top_p))
            top = top_c;
        sh_p_s = top - top_p;
        sh_c_s = top - top_c;
        sh_p   = (sh_p_s > 12'sd64) ? 7'd64 : sh_p_s[6:0];
        sh_c   = (sh_c_s > 12'sd64) ? 7'd64 : sh_c_s[6:0];
        wide_p = {(p_zero ? 16'd0 : prod), 80'd0} >> sh_p;
        wide_c = {(c_zero ? 8'd0 : {1'b1, in_c[6:0]}), 88'd0} >> sh_c;
        // Bit 0 only ever holds lost bits, and only when subtracting, so truncation stays exact
        al_p = {1'b0, wide_p[95:49], eff_sub & (|wide_p[48:0])};
        al_c = {1'b0, wide_c[95:49], eff_sub & (|wide_c[48:0])};

        if (!eff_sub) begin
            sum      = al_p + al_c;
            res_sign = sp;
        end else if (al_p >= al_c) begin
            sum      = al_p - al_c;
            res_sign = sp;
        end else begin
            sum      = al_c - al_p;
            res_sign = sc;
        end

        msb = '0;
        for (int i = 0; i < 49; i++)
            if (sum[i]) msb = 6'(i);
        e_res = top + 12'sd80 + $signed({6'b0, msb});
        man   = 7'((sum << (6'd48 - msb)) >> 41);

        mac_out   = ZERO;
        exception = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (a_nan | b_nan | c_nan | (a_inf & b_zero) | (b_inf & a_zero) | (p_inf & c_inf & eff_sub)) begin
            mac_out   = BF16_QNAN;
            exception = 1'b1;
        end else if (p_inf) begin
            mac_out = {sp, 8'hFF, 7'd0};
        end else if (c_inf) begin
            mac_out = in_c;
        end else if (sum == '0) begin
            mac_out = {p_zero & c_zero & sp & sc, 15'd0};
        end else if (e_res >= 12'sd255) begin
            mac_out  = {res_sign, 8'hFF, 7'd0};
            overflow = 1'b1;
        end else if (e_res <= 12'sd0) begin
            mac_out   = {res_sign, 15'd0};
            underflow = 1'b1;
        end else begin
            mac_out = {res_sign, e_res[7:0], man};
        end
    end

endmodule

// File: rtl/mac_dot_sequencer.sv
// rtl/mac_dot_sequencer.sv - bfloat16 dot product with bias over one shared mac_unit
module mac_dot_sequencer
    import mac_pkg::*;
#(
    parameter int BIT_WIDTH = BF16_WIDTH,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic [BIT_WIDTH-1:0] cmd_bias,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [BIT_WIDTH-1:0] op_a,
    input  logic [BIT_WIDTH-1:0] op_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [BIT_WIDTH-1:0] res_data,
    output logic                 res_exception,
    output logic                 res_overflow,
    output logic                 res_underflow,
    output logic                 busy
);

    seq_state_t           state, state_nxt;
    logic [BIT_WIDTH-1:0] acc, a_q, b_q, mac_out;
    logic [LEN_WIDTH-1:0] cnt;
    logic                 f_exc, f_ovf, f_unf;
    logic                 mac_exc, mac_ovf, mac_unf;

    mac_unit u_mac (
        .in_a      (a_q),
        .in_b      (b_q),
        .in_c      (acc),
        .mac_out   (mac_out),
        .exception (mac_exc),
        .overflow  (mac_ovf),
        .underflow (mac_unf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = (cmd_len != '0) ? LOAD : DONE;
            end
            LOAD: begin
                op_ready = 1'b1;
                if (op_valid) state_nxt = EXEC;
            end
            EXEC:    state_nxt = (cnt != '0) ? LOAD : DONE;
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt   <= '0;
            f_exc <= 1'b0;
            f_ovf <= 1'b0;
            f_unf <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    acc   <= cmd_bias;
                    cnt   <= cmd_len;
                    f_exc <= 1'b0;
                    f_ovf <= 1'b0;
                    f_unf <= 1'b0;
                end
                LOAD: if (op_valid) begin
                    a_q <= op_a;
                    b_q <= op_b;
                    cnt <= cnt - LEN_WIDTH'(1);
                end
                EXEC: begin
                    acc   <= mac_out;
                    f_exc <= f_exc | mac_exc;
                    f_ovf <= f_ovf | mac_ovf;
                    f_unf <= f_unf | mac_unf;
                end
                default: ;
            endcase
        end
    end

    // Result outputs read the live registers; they only move outside DONE
    assign res_data      = acc;
    assign res_exception = f_exc;
    assign res_overflow  = f_ovf;
    assign res_underflow = f_unf;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb/tb_mac_dot_sequencer.sv - self-checking bench for mac_dot_sequencer
module tb_mac_dot_sequencer;
    import mac_pkg::*;

    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len = '0;
    logic [15:0]   cmd_bias = '0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [15:0]   op_a = '0;
    logic [15:0]   op_b = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [15:0]   res_data;
    logic          res_exception, res_overflow, res_underflow;
    logic          busy;

    mac_dot_sequencer #(.BIT_WIDTH(16), .LEN_WIDTH(LW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_len       (cmd_len),
        .cmd_bias      (cmd_bias),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_exception (res_exception),
        .res_overflow  (res_overflow),
        .res_underflow (res_underflow),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference: exact real arithmetic per step, truncated toward zero to bfloat16
    function automatic real bf2r(input logic [15:0] x);
        logic [63:0] d;
        if (x[14:7] == 8'd0) return 0.0;
        d = {x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [17:0] r2bf(input real r);
        logic [63:0] d;
        int          be;
        if (r == 0.0) return 18'd0;
        d  = $realtobits(r);
        be = int'(d[62:52]) - 896;
        if (be >= 255) return {2'b10, d[63], 8'hFF, 7'd0};
        if (be <= 0)   return {2'b01, d[63], 15'd0};
        return {2'b00, d[63], be[7:0], d[51:45]};
    endfunction

    logic [15:0] pa[$];
    logic [15:0] pb[$];

    function automatic logic [18:0] model_dot(input logic [15:0] bias);
        logic [15:0] acc = bias;
        logic [1:0]  fl  = 2'b00;
        logic [17:0] t;
        for (int i = 0; i < pa.size(); i++) begin
            t   = r2bf(bf2r(pa[i]) * bf2r(pb[i]) + bf2r(acc));
            acc = t[15:0];
            fl  = fl | t[17:16];
        end
        return {1'b0, fl, acc};
    endfunction

    function automatic logic [15:0] rnd_bf();
        return {1'($urandom), 8'($urandom_range(124, 130)), 7'($urandom)};
    endfunction

    logic [15:0] r_data;
    logic [2:0]  r_flags;
    logic [1:0]  r_after;
    int          r_lat, r_wait, r_busy_ready, r_hold_bad;
    bit          r_op_seen;

    // Called at a negedge; returns at the negedge after the result handshake
    task automatic run_cmd(input logic [15:0] bias, input int gap, input int hold, input bit offer_busy);
        int          n = pa.size();
        int          idx = 0;
        int          gapc = 0;
        int          budget = 0;
        int          hs;
        logic [15:0] held_d;
        logic [2:0]  held_f;
        r_wait = 0; r_busy_ready = 0; r_op_seen = 0; r_hold_bad = 0;
        cmd_valid = 1'b1;
        cmd_bias  = bias;
        cmd_len   = LW'(n);
        while (!cmd_ready && r_wait < 50) begin
            @(negedge clk);
            r_wait++;
        end
        hs = edges + 1;
        @(negedge clk);
        cmd_valid = offer_busy;
        cmd_bias  = 16'h4480;
        cmd_len   = LW'(1);
        while (!res_valid && budget < 2000) begin
            if (cmd_ready) r_busy_ready++;
            if (op_ready) r_op_seen = 1'b1;
            if (gapc > 0) begin
                op_valid = 1'b0;
                gapc--;
            end else if (idx < n) begin
                op_valid = 1'b1;
                op_a     = pa[idx];
                op_b     = pb[idx];
            end else begin
                op_valid = 1'b0;
            end
            if (op_valid && op_ready) begin
                idx++;
                gapc = gap;
            end
            @(negedge clk);
            budget++;
        end
        op_valid = 1'b0;
        check("res_valid_reached", {31'd0, res_valid}, 32'd1);
        r_lat  = edges - hs + 1;
        held_d = res_data;
        held_f = {res_exception, res_overflow, res_underflow};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (res_data !== held_d || {res_exception, res_overflow, res_underflow} !== held_f
                || !res_valid || cmd_ready || !busy)
                r_hold_bad++;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        r_data    = res_data;
        r_flags   = {res_exception, res_overflow, res_underflow};
        @(negedge clk);
        res_ready = 1'b0;
        r_after   = {res_valid, cmd_ready};
    endtask

    initial begin
        logic [18:0] m;
        logic [15:0] bias;
        int          n, gap, hold;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outputs", {26'd0, op_ready, res_valid, busy, res_exception, res_overflow, res_underflow}, 32'd0);
        check("rst_res_data", {16'd0, res_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Basic dot: 1 + 2*3 + 0.5*2 = 8
        pa = '{16'h4000, 16'h3F00};
        pb = '{16'h4040, 16'h4000};
        run_cmd(ONE, 0, 0, 1'b0);
        check("basic_data", {16'd0, r_data}, 32'h4100);
        check("basic_flags", {29'd0, r_flags}, 32'd0);
        check("basic_latency", r_lat, 32'd5);
        check("basic_after", {30'd0, r_after}, 32'b01);

        // Zero length
        pa.delete(); pb.delete();
        run_cmd(16'h40E0, 0, 0, 1'b0);
        check("zero_data", {16'd0, r_data}, 32'h40E0);
        check("zero_latency", r_lat, 32'd1);
        check("zero_no_op_ready", {31'd0, r_op_seen}, 32'd0);

        // Sticky overflow, then back-to-back command with cleared flags
        pa = '{16'h7F7F, ZERO};
        pb = '{16'h7F7F, ZERO};
        run_cmd(ZERO, 0, 0, 1'b0);
        check("sticky_data", {16'd0, r_data}, 32'h7F80);
        check("sticky_flags", {29'd0, r_flags}, 32'b010);
        pa = '{16'h4000};
        pb = '{16'h3F80};
        run_cmd(ONE, 0, 0, 1'b0);
        check("b2b_no_wait", r_wait, 32'd0);
        check("b2b_data", {16'd0, r_data}, 32'h4040);
        check("b2b_flags", {29'd0, r_flags}, 32'd0);

        // Backpressure: 1 + 1.5*2 - 2*1 + 4*0.25 = 3
        pa = '{16'h3FC0, 16'hC000, 16'h4080};
        pb = '{16'h4000, 16'h3F80, 16'h3E80};
        run_cmd(ONE, 0, 0, 1'b0);
        check("bp_nogap_data", {16'd0, r_data}, 32'h4040);
        check("bp_nogap_latency", r_lat, 32'd7);
        run_cmd(ONE, 3, 5, 1'b1);
        check("bp_gap_data", {16'd0, r_data}, 32'h4040);
        check("bp_gap_flags", {29'd0, r_flags}, 32'd0);
        check("bp_hold_stable", r_hold_bad, 32'd0);
        check("bp_busy_cmd_ready", r_busy_ready, 32'd0);

        // Reset during EXEC of pair 2 of N=4
        cmd_valid = 1'b1; cmd_bias = ONE; cmd_len = LW'(4);
        @(negedge clk);
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_a = 16'h4000; op_b = 16'h4000;
        repeat (3) @(negedge clk);
        check("pre_rst_exec", {29'd0, busy, op_ready, res_valid}, 32'b100);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {26'd0, op_ready, res_valid, busy, res_exception, res_overflow, res_underflow}, 32'd0);
        check("midrst_res_data", {16'd0, res_data}, 32'd0);
        @(negedge clk);
        op_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("midrst_idle", {30'd0, cmd_ready, busy}, 32'b10);
        pa = '{16'h4000};
        pb = '{16'h3F80};
        run_cmd(ONE, 0, 0, 1'b0);
        check("post_rst_data", {16'd0, r_data}, 32'h4040);

        // Randomized commands against the reference
        for (int t = 0; t < 25; t++) begin
            n    = $urandom_range(1, 6);
            gap  = $urandom_range(0, 2);
            hold = $urandom_range(0, 2);
            pa.delete(); pb.delete();
            for (int i = 0; i < n; i++) begin
                pa.push_back(rnd_bf());
                pb.push_back(rnd_bf());
            end
            bias = rnd_bf();
            m    = model_dot(bias);
            run_cmd(bias, gap, hold, 1'(t));
            check("rnd_data", {16'd0, r_data}, {16'd0, m[15:0]});
            check("rnd_flags", {29'd0, r_flags}, {29'd0, m[18:16]});
            if (gap == 0) check("rnd_latency", r_lat, 2 * n + 1);
        end

        // Maximum length command
        pa.delete(); pb.delete();
        for (int i = 0; i < 255; i++) begin
            pa.push_back(rnd_bf());
            pb.push_back(rnd_bf());
        end
        bias = rnd_bf();
        m    = model_dot(bias);
        run_cmd(bias, 0, 1, 1'b0);
        check("max_len_data", {16'd0, r_data}, {16'd0, m[15:0]});
        check("max_len_flags", {29'd0, r_flags}, {29'd0, m[18:16]});
        check("max_len_latency", r_lat, 32'd511);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
